// File: rtl/clemensnasenberg_i2s_tx.sv
// I2S transmitter (bus master): generates ws framing from a free-running bit
// counter and shifts out one buffered left/right pair per frame, MSB first,
// with the standard one-bit delay after each ws transition.
//
// Handshake: the source holds in_valid with stable left_in/right_in until a
// posedge where in_valid && in_ready; on that edge both samples are captured
// into the holding buffer. in_ready is a register (= buffer empty), so it
// never depends combinationally on in_valid.
module clemensnasenberg_i2s_tx #(
    parameter int WIDTH      = 24,
    parameter int SLOT_WIDTH = 32
) (
    input  logic             sck,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] left_in,
    input  logic [WIDTH-1:0] right_in,
    output logic             ws,
    output logic             sd,
    output logic             underrun
);

    localparam int FRAME = 2 * SLOT_WIDTH;
    localparam int CW    = (FRAME > 1) ? $clog2(FRAME) : 1;

    localparam logic [CW-1:0] LAST_C  = CW'(FRAME - 1);
    localparam logic [CW-1:0] SLOT_C  = CW'(SLOT_WIDTH);
    localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);
    localparam logic [CW-1:0] MSB_C   = CW'(WIDTH - 1);

    // run_q is clear only in the cycle right after a reset edge, so the
    // release edge leaves the counter at 0 instead of advancing it.
    logic             run_q, run_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             full_q, full_d;
    logic [WIDTH-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;
    logic [WIDTH-1:0] act_l_q, act_l_d, act_r_q, act_r_d;
    logic             ready_q, ready_d;
    logic             ws_q, ws_d;
    logic             sd_q, sd_d;
    logic             underrun_q, underrun_d;

    logic             wrap;
    logic             accept;
    logic [CW-1:0]    pos;
    logic [CW-1:0]    bit_idx;
    logic             right_slot;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] shifted;

    // Framing counter, holding buffer / active pair handover and handshake.
    always_comb begin
        wrap       = run_q && (cnt_q == LAST_C);
        accept     = in_valid && ready_q;
        run_d      = 1'b1;
        cnt_d      = '0;
        full_d     = full_q;
        buf_l_d    = buf_l_q;
        buf_r_d    = buf_r_q;
        act_l_d    = act_l_q;
        act_r_d    = act_r_q;
        underrun_d = 1'b0;
        if (run_q && !wrap) begin
            cnt_d = cnt_q + CW'(1);
        end
        if (wrap) begin
            if (full_q) begin
                act_l_d = buf_l_q;
                act_r_d = buf_r_q;
                full_d  = 1'b0;
            end else begin
                act_l_d    = '0;
                act_r_d    = '0;
                underrun_d = 1'b1;
            end
        end
        // A full buffer keeps in_ready low, so accept never coincides with
        // the wrap that empties the buffer.
        if (accept) begin
            buf_l_d = left_in;
            buf_r_d = right_in;
            full_d  = 1'b1;
        end
        ready_d = !full_d;
        ws_d    = (cnt_d >= SLOT_C);
    end

    // Serial bit for the upcoming counter value, one bit behind ws. The
    // active pair is taken before any wrap update, so cnt=0 still carries
    // the previous frame's last right-slot bit.
    always_comb begin
        pos        = (cnt_d == '0) ? LAST_C : cnt_d - CW'(1);
        right_slot = (pos >= SLOT_C);
        bit_idx    = right_slot ? pos - SLOT_C : pos;
        word       = right_slot ? act_r_q : act_l_q;
        shifted    = '0;
        sd_d       = 1'b0;
        if (bit_idx < WIDTH_C) begin
            shifted = word >> (MSB_C - bit_idx);
            sd_d    = shifted[0];
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge sck) begin
        if (!reset) begin
            run_q      <= 1'b0;
            cnt_q      <= '0;
            full_q     <= 1'b0;
            buf_l_q    <= '0;
            buf_r_q    <= '0;
            act_l_q    <= '0;
            act_r_q    <= '0;
            ready_q    <= 1'b0;
            ws_q       <= 1'b0;
            sd_q       <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            run_q      <= run_d;
            cnt_q      <= cnt_d;
            full_q     <= full_d;
            buf_l_q    <= buf_l_d;
            buf_r_q    <= buf_r_d;
            act_l_q    <= act_l_d;
            act_r_q    <= act_r_d;
            ready_q    <= ready_d;
            ws_q       <= ws_d;
            sd_q       <= sd_d;
            underrun_q <= underrun_d;
        end
    end

    assign in_ready = ready_q;
    assign ws       = ws_q;
    assign sd       = sd_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_clemensnasenberg_i2s_tx.sv
// Bench for clemensnasenberg_i2s_tx: a time-indexed reference model predicts
// every output each cycle, a deserializer rebuilds frames from ws/sd for a
// pair scoreboard, plus table vectors and hand-written corner sequences.
module tb_clemensnasenberg_i2s_tx;

    localparam int W = 24;
    localparam int S = 32;
    localparam int F = 2 * S;

    logic         sck = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] left_in = '0;
    logic [W-1:0] right_in = '0;
    logic         in_ready;
    logic         ws;
    logic         sd;
    logic         underrun;

    clemensnasenberg_i2s_tx #(.WIDTH(W), .SLOT_WIDTH(S)) dut (
        .sck      (sck),
        .reset    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .left_in  (left_in),
        .right_in (right_in),
        .ws       (ws),
        .sd       (sd),
        .underrun (underrun)
    );

    always #5 sck = ~sck;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: k = cycles since release (-1 = reset cycle).
    int             k = -1;
    bit             model_on = 1'b0;
    int             acc_cnt = 0;
    int             last_target = 0;
    bit             acc_frame[int];
    logic [2*W-1:0] play[int];
    logic [63:0]    cap_frame[int];
    logic [63:0]    fb = '0;
    logic [2*W-1:0] exp_q[$];

    typedef struct {
        logic [W-1:0] l;
        logic [W-1:0] r;
        logic [63:0]  frame;
    } vec_t;
    vec_t tbl[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got %h expected %h (k=%0d)", name, act, exp, k);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out (k=%0d)", name, k);
    endtask

    function automatic bit model_ready(input int kk);
        return (kk >= 0) && !acc_frame.exists(kk / F);
    endfunction

    function automatic logic exp_sd(input int kk);
        int g, p, b;
        logic [2*W-1:0] pr;
        logic [W-1:0] w;
        if (kk < 1) return 1'b0;
        g = (kk - 1) / F;
        p = (kk - 1) % F;
        if (!play.exists(g)) return 1'b0;
        pr = play[g];
        w  = (p < S) ? pr[2*W-1:W] : pr[W-1:0];
        b  = p % S;
        if (b >= W) return 1'b0;
        return w[W-1-b];
    endfunction

    // {in_ready, ws, sd, underrun} expected in state kk.
    function automatic logic [3:0] exp_vec(input int kk);
        logic rdy, wsb, sdb, ur;
        if (kk < 0) return 4'b0000;
        rdy = model_ready(kk);
        wsb = (kk % F) >= S;
        sdb = exp_sd(kk);
        ur  = (kk > 0) && (kk % F == 0) && !play.exists(kk / F);
        return {rdy, wsb, sdb, ur};
    endfunction

    // Reference model advance: an accept on the edge into state j plays in
    // frame j/F + 1; at most one accept per frame.
    initial forever begin
        @(posedge sck);
        if (!rst_n) begin
            k = -1;
            model_on = 1'b1;
            acc_frame.delete();
            play.delete();
            cap_frame.delete();
            exp_q.delete();
        end else if (model_on) begin
            if (in_valid && model_ready(k)) begin
                acc_frame[(k + 1) / F] = 1'b1;
                play[(k + 1) / F + 1]  = {left_in, right_in};
                exp_q.push_back({left_in, right_in});
                last_target = (k + 1) / F + 1;
                acc_cnt++;
            end
            k = k + 1;
        end
    end

    // Per-cycle output check and frame deserializer / pair scoreboard.
    initial forever begin
        @(negedge sck);
        if (model_on) begin
            check("cycle", {60'd0, in_ready, ws, sd, underrun}, {60'd0, exp_vec(k)});
            if (k >= 1) begin
                fb = {fb[62:0], sd};
                if (k % F == 0) begin
                    cap_frame[(k - 1) / F] = fb;
                    if (play.exists((k - 1) / F)) begin
                        if (exp_q.size() == 0) fail_now("scoreboard_underflow");
                        else check("loopback", {16'd0, fb[63-:W], fb[31-:W]}, {16'd0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge sck);
    endtask

    task automatic wait_cnt(input int c);
        for (int i = 0; i < 4 * F; i++) begin
            if (k >= 0 && (k % F) == c) return;
            @(negedge sck);
        end
        fail_now("wait_cnt");
    endtask

    task automatic send_pair(input logic [W-1:0] l, input logic [W-1:0] r);
        int start;
        start    = acc_cnt;
        left_in  = l;
        right_in = r;
        in_valid = 1'b1;
        for (int i = 0; i < 3 * F; i++) begin
            @(negedge sck);
            if (acc_cnt != start) begin
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        fail_now("send_pair");
    endtask

    task automatic wait_frame(input int t);
        for (int i = 0; i < 4 * F; i++) begin
            if (cap_frame.exists(t)) return;
            @(negedge sck);
        end
        fail_now("wait_frame");
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 4 * F; i++) begin
            if (exp_q.size() == 0) return;
            @(negedge sck);
        end
        fail_now("drain");
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        tick(3);
        rst_n = 1'b1;
        @(negedge sck);
        check("release_ready", {63'd0, in_ready}, 64'd1);
        check("release_ws", {63'd0, ws}, 64'd0);
    endtask

    initial begin
        int t;
        int ones;
        logic [W-1:0] bl, br;

        tbl[0] = '{l: 24'hA5A5A5, r: 24'h5A5A5A, frame: 64'hA5A5A500_5A5A5A00};
        tbl[1] = '{l: 24'h800001, r: 24'h7FFFFF, frame: 64'h80000100_7FFFFF00};
        tbl[2] = '{l: 24'hFFFFFF, r: 24'h000000, frame: 64'hFFFFFF00_00000000};
        tbl[3] = '{l: 24'h000001, r: 24'h800000, frame: 64'h00000100_80000000};

        // Reset and idle: zeros, ws toggling, underrun from frame 1 on.
        do_reset();
        tick(5 * S);

        // Table vectors; the first pair is accepted during frame 0.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wait_cnt(5);
            send_pair(tbl[i].l, tbl[i].r);
            t = last_target;
            wait_frame(t);
            check("table_frame", cap_frame.exists(t) ? cap_frame[t] : 64'd0, tbl[i].frame);
        end

        // Back-pressure: valid held high for several frames.
        left_in  = 24'h800001;
        right_in = 24'h7FFFFF;
        in_valid = 1'b1;
        tick(4 * F);
        in_valid = 1'b0;
        wait_drain();
        tick(F + 4);

        // Boundary accept on the wrap edge with an empty buffer.
        bl = W'($urandom);
        br = W'($urandom);
        wait_cnt(F - 1);
        send_pair(bl, br);
        check("boundary_cnt0", {32'd0, k % F}, 64'd0);
        check("boundary_underrun", {63'd0, underrun}, 64'd1);
        t = last_target;
        wait_frame(t);
        check("boundary_zero_frame", cap_frame.exists(t - 1) ? cap_frame[t - 1] : 64'hFFFF, 64'd0);
        check("boundary_play_frame", cap_frame.exists(t) ? cap_frame[t] : 64'd0,
              {bl, 8'd0, br, 8'd0});

        // Random chain of pairs with random gaps.
        for (int i = 0; i < 8; i++) begin
            tick($urandom_range(0, 70));
            send_pair(W'($urandom), W'($urandom));
        end
        wait_drain();
        check("random_drained", {32'd0, exp_q.size()}, 64'd0);

        // Mid-frame reset with a pair playing and another buffered.
        wait_cnt(10);
        send_pair(24'h123456, 24'h654321);
        wait_cnt(10);
        send_pair(24'hFEDCBA, 24'hABCDEF);
        wait_cnt(40);
        rst_n = 1'b0;
        @(negedge sck);
        check("rst_ws", {63'd0, ws}, 64'd0);
        check("rst_sd", {63'd0, sd}, 64'd0);
        check("rst_ready", {63'd0, in_ready}, 64'd0);
        tick(2);
        rst_n = 1'b1;
        @(negedge sck);
        check("rst_restart_cnt", {32'd0, k}, 64'd0);
        ones = 0;
        for (int i = 0; i < 2 * F + 10; i++) begin
            ones += int'(sd);
            @(negedge sck);
        end
        check("post_reset_silent", {32'd0, ones}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/clemensnasenberg_i2s_tx.md
# clemensnasenberg_i2s_tx

I2S transmitter (bus master) that serializes parallel left/right audio samples onto a two-wire serial bus (`ws`, `sd`), clocked by `sck`. It is the transmit end of the team's I2S receiver and sits between a sample source and the receiver's `ws`/`sd` inputs. The transmitter generates the word-select framing itself. It buffers one stereo pair through a valid/ready handshake so the source has a full frame of slack, and it flags underruns when no pair is ready.

## Interface
- `WIDTH`, 24, sample width in bits, 1..SLOT_WIDTH
- `SLOT_WIDTH`, 32, bit clocks per channel slot; frame = 2*SLOT_WIDTH cycles
- `sck`  in  1  bit clock; all state changes on posedge
- `reset`  in  1  synchronous active-low reset (0 = reset, sampled on posedge `sck`)
- `in_valid`  in  1  source offers `left_in`/`right_in`
- `in_ready`  out  1  holding buffer empty; transfer when `in_valid & in_ready` at posedge
- `left_in`  in  WIDTH  left sample, two's complement, MSB first on wire
- `right_in`  in  WIDTH  right sample
- `ws`  out  1  word select: 0 = left slot, 1 = right slot
- `sd`  out  1  serial data
- `underrun`  out  1  one-cycle pulse: frame started with empty buffer

## Operation
- Bit counter `cnt` runs 0..2*SLOT_WIDTH-1, increments every cycle, wraps to 0.
- `ws` = 1 when `cnt >= SLOT_WIDTH`, else 0.
- Standard I2S one-bit delay: let p = (cnt-1) mod 2*SLOT_WIDTH, ch = left if p < SLOT_WIDTH else right, b = p mod SLOT_WIDTH; `sd` = active_ch[WIDTH-1-b] if b < WIDTH, else 0. Left MSB therefore appears at cnt=1, one cycle after `ws` falls; right LSB/pad bit appears at cnt=0 of the next frame.
- Storage: holding buffer (left, right, full flag) and active pair (left, right).
- Handshake: `in_ready` = !full (registered). An accept sets full and captures both inputs. Inputs are ignored when `in_ready`=0.
- Wrap edge (posedge where cnt goes 2*SLOT_WIDTH-1 -> 0):
  - If full: active <= buffer, full <= 0.
  - If empty: active <= 0, `underrun` = 1 during cycle cnt=0.
  - The old active right is still used for `sd` at cnt=0.
- Accept and wrap on the same edge with an empty buffer: the sample goes into the buffer (full=1), the new frame is zeros, and `underrun` pulses. The sample plays in the following frame.
- Accept is impossible on the same edge that empties a full buffer, because `in_ready` was 0. `in_ready` rises the cycle after the wrap.
- Outputs are driven from registers only; no combinational path from inputs to outputs.

## Timing
- Reset (held low at posedge): cnt=0, active=0, full=0, `ws`=0, `sd`=0, `underrun`=0, `in_ready`=0.
- First cycle after release: cnt=0, `in_ready`=1.
- Frame 0 after reset transmits zeros and does not flag underrun.
- First wrap occurs 2*SLOT_WIDTH cycles after release.
- Latency: a pair accepted during frame N is transmitted in frame N+1. Left MSB appears at cnt=1 of frame N+1.
- Throughput: one pair per 2*SLOT_WIDTH cycles.
- Reset asserted mid-frame: all state returns to reset values on that edge. Any buffered or active pair is discarded. Framing restarts at cnt=0.
- WIDTH == SLOT_WIDTH: no pad bits. Right LSB is at cnt=0 of the next frame.

## Test plan
- Reset/idle: hold reset low 3 cycles, release, no `in_valid` -> `ws` toggles every 32 cycles starting at 0; `sd`=0 throughout; `underrun` pulses at cnt=0 of every frame from frame 1 on; never in frame 0.
- Single pair: accept left=0xA5A5A5, right=0x5A5A5A during frame 0 -> frame 1 `sd` at cnt 1..24 = A5A5A5 MSB first, cnt 25..32 = 0, cnt 33..56 = 5A5A5A, cnt 57..63 and next cnt 0 = 0; no underrun in frame 1.
- Back-pressure: hold `in_valid`=1 with left=0x800001, right=0x7FFFFF continuously -> `in_ready` low except one cycle after each wrap; one accept per frame; every frame is bit-exact; no underrun after frame 1.
- Boundary accept: present a pair exactly on the wrap edge with the buffer empty -> `underrun` pulses at cnt=0; that frame is zeros; the pair plays in the next frame.
- Loopback: drive a chain of 8 random pairs into the team's I2S receiver (`sck`/`ws`/`sd` connected) -> receiver left/right captures match the transmitted pairs in order.
- Mid-frame reset: assert reset at cnt=40 with the buffer full -> `ws`=0 and `sd`=0 on the next cycle; `in_ready`=0 during reset; after release the buffered pair is never transmitted and the frame counter restarts at 0.
